rib_sram_slave: RTL and testbench
=================================

# rib_sram_slave

RIB-bus responder: a single-port word-addressed SRAM that answers the core's external RIB initiator port (`o_ribx_*` / `i_ribx_*` of `CORE_TOP`), which is currently tied off at SoC top. It accepts requests through the req/gnt handshake and returns in-order responses through rsp/rdy. A 2-entry response FIFO lets back-to-back accesses run at one per cycle. Optional programmable wait states emulate slower external memory.

## Interface
- `BASE_ADDR`, default `32'h2000_0000`: byte address of word 0.
- `DEPTH_LOG2`, default 12: log2 of the word count (4096 words = 16 KiB).
- `WAIT_CYC`, default 0: extra cycles between accept and access (0..15).
- `i_clk` in 1: sole clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_ribs_addr` in 32: byte address; bits [1:0] are ignored.
- `i_ribs_wrcs` in 1: 1 = write, 0 = read.
- `i_ribs_mask` in 4: byte enables for writes; bit n enables byte lane n (bits [8n+7:8n]).
- `i_ribs_wdata` in 32: write data.
- `o_ribs_rdata` out 32: response data.
- `i_ribs_req` in 1: request valid.
- `o_ribs_gnt` out 1: request accepted when `req && gnt`.
- `o_ribs_rsp` out 1: response valid.
- `i_ribs_rdy` in 1: initiator consumes the response when `rsp && rdy`.

## Operation
- **State machine:** `IDLE` and `WAIT`.
- **Grant:** `o_ribs_gnt = !i_rst && state==IDLE && fifo_cnt<2`.
- **Accept, WAIT_CYC=0:** the access is performed on the accept edge, and the result is pushed to the FIFO on the same edge. State stays `IDLE`.
- **Accept, WAIT_CYC>0:**
  - On the accept edge, addr/wrcs/mask/wdata are latched, `wcnt` is loaded with `WAIT_CYC`, and the state goes to `WAIT`.
  - `wcnt` decrements each cycle.
  - On the edge where `wcnt==1`, the latched access is performed, the result is pushed, and the state returns to `IDLE`.
- **FIFO space during WAIT:** admission requires `fifo_cnt<2` and nothing else pushes during `WAIT`, so the push never overflows.
- **Write:** each byte lane with its mask bit set is updated. The response pushes `rdata = 32'h0`. A write with mask `4'b0000` still returns a response and changes nothing.
- **Read:** returns the full word; mask is ignored.
- **Indexing:** word index is `(addr - BASE_ADDR) >> 2`, truncated to `DEPTH_LOG2` bits.
- **Response FIFO:** 2 entries of 32-bit data, with read and write pointers that wrap at 2.
  - `o_ribs_rsp = fifo_cnt != 0`; `o_ribs_rdata` is the head entry.
  - On simultaneous push and pop, the count is unchanged.
  - Pop is ignored when the FIFO is empty.
- **Ordering:** responses are strictly in request order.
- **Reset:** asserting reset mid-operation discards all pending FIFO entries and any `WAIT` access in progress (an unperformed write is lost). State returns to `IDLE` and `wcnt` clears. Memory contents are never reset.

## Timing
- **Reset values:** `o_ribs_gnt=0`, `o_ribs_rsp=0`, `o_ribs_rdata=32'h0`, `fifo_cnt=0`, state `IDLE`.
- **Latency:** accept at edge N makes `rsp` visible in cycle N+1+WAIT_CYC.
- **Throughput, WAIT_CYC=0:** one request per cycle while `rdy` is held high (`fifo_cnt` steady at 1). With `rdy` low, two requests are accepted, then `gnt` drops until a pop.
- **Throughput, WAIT_CYC>0:** at most one access in flight. `gnt` is low for the WAIT_CYC cycles after each accept.
- **Response stability:** `o_ribs_rdata` is stable while `rsp && !rdy`.
- **`gnt` path:** combinational from registered state only. It does not depend on `req` or `rdy`, so a pop in cycle N raises `gnt` in cycle N+1.
- **Read-after-write:** a read accepted the cycle after a write to the same word returns the new data.

## Configuration
- **`RIB_SRAM_RANGE_CHK_EN` defined:**
  - An access with `addr < BASE_ADDR` or `addr >= BASE_ADDR + 4*2^DEPTH_LOG2` is out of range.
  - Out-of-range writes are dropped and respond with `rdata=32'h0`.
  - Out-of-range reads respond with `32'hDEAD_BEEF`.
  - Timing is identical to in-range accesses.
- **Not defined:** no range check. Addresses alias modulo the array size, and every access touches memory.

## Test plan
- **Reset values:** hold `i_rst`=1 with `req`=1 → `gnt`=0, `rsp`=0, `rdata`=0. Release reset → `gnt`=1 the next cycle.
- **Byte-masked write, then read:** WAIT_CYC=0. Write `32'h1122_3344` with mask `4'hF` to `BASE+0x10`. Write `32'hAABB_CCDD` with mask `4'b0101` to the same address. Read it → `rdata=32'h11BB_33DD`. Each response is 1 cycle after its accept; write responses return 0.
- **Back-pressure:** WAIT_CYC=0, `rdy`=0, 3 reads issued → 2 accepted, `gnt`=0 on the third. Raise `rdy` for one cycle → one response pops, and the third read is accepted next cycle. The three responses arrive in order.
- **Streaming:** WAIT_CYC=0, `rdy`=1, 8 consecutive reads → 8 accepts in 8 cycles. `rsp` is high from cycle 2 through cycle 9.
- **Wait states:** WAIT_CYC=3. Read accepted at edge N → `rsp` in cycle N+4, `gnt` low in cycles N+1..N+3. Assert `i_rst` in cycle N+2 → no response, state `IDLE`.
- **Range check:** with `RIB_SRAM_RANGE_CHK_EN`, a read at `BASE-4` → `32'hDEAD_BEEF`. Without it, a write at `BASE + 4*4096` aliases, and a read of word 0 returns the written value.

Source files
------------

// File: rtl/rib_sram_slave.sv
// rtl/rib_sram_slave.sv - RIB responder with word SRAM, 2-entry response FIFO and optional wait states
// Optional RIB_SRAM_RANGE_CHK_EN: drop out-of-range writes, answer out-of-range reads with DEADBEEF.
module rib_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          WAIT_CYC   = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic        lat_wrcs_q, lat_wrcs_d;
    logic [3:0]  lat_mask_q, lat_mask_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;

    logic [31:0] fifo_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH];

    logic                  accept, pop, acc_fire, acc_wrcs, in_range, mem_we;
    logic [31:0]           acc_addr, acc_wdata, offset, push_data;
    logic [3:0]            acc_mask;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_offset;

    assign o_ribs_gnt   = !i_rst && (state_q == ST_IDLE) && (cnt_q < 2'd2);
    assign o_ribs_rsp   = (cnt_q != 2'd0);
    assign o_ribs_rdata = fifo_q[rptr_q];
    assign accept       = i_ribs_req && o_ribs_gnt;
    assign pop          = o_ribs_rsp && i_ribs_rdy;

    // Without wait states the bus fields are used directly on the accept edge.
    always_comb begin
        acc_fire  = 1'b0;
        acc_addr  = i_ribs_addr;
        acc_wrcs  = i_ribs_wrcs;
        acc_mask  = i_ribs_mask;
        acc_wdata = i_ribs_wdata;
        if (WAIT_CYC == 0) begin
            acc_fire = accept;
        end else begin
            acc_fire  = (state_q == ST_WAIT) && (wcnt_q == 4'd1);
            acc_addr  = lat_addr_q;
            acc_wrcs  = lat_wrcs_q;
            acc_mask  = lat_mask_q;
            acc_wdata = lat_wdata_q;
        end
    end

    assign offset        = acc_addr - BASE_ADDR;
    assign idx           = offset[DEPTH_LOG2+1:2];
    assign unused_offset = ^offset;

`ifdef RIB_SRAM_RANGE_CHK_EN
    localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;
    assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
`else
    assign in_range = 1'b1;
`endif

    assign mem_we = acc_fire && acc_wrcs && in_range;

    always_comb begin
        push_data = 32'h0;
        if (!acc_wrcs) begin
            push_data = in_range ? mem_q[idx] : 32'hDEAD_BEEF;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        lat_addr_d  = lat_addr_q;
        lat_wrcs_d  = lat_wrcs_q;
        lat_mask_d  = lat_mask_q;
        lat_wdata_d = lat_wdata_q;
        cnt_d       = cnt_q + {1'b0, acc_fire} - {1'b0, pop};
        case (state_q)
            ST_IDLE: begin
                if (accept && (WAIT_CYC != 0)) begin
                    state_d     = ST_WAIT;
                    wcnt_d      = 4'(WAIT_CYC);
                    lat_addr_d  = i_ribs_addr;
                    lat_wrcs_d  = i_ribs_wrcs;
                    lat_mask_d  = i_ribs_mask;
                    lat_wdata_d = i_ribs_wdata;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            lat_addr_q  <= 32'h0;
            lat_wrcs_q  <= 1'b0;
            lat_mask_q  <= 4'h0;
            lat_wdata_q <= 32'h0;
            fifo_q[0]   <= 32'h0;
            fifo_q[1]   <= 32'h0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_wrcs_q  <= lat_wrcs_d;
            lat_mask_q  <= lat_mask_d;
            lat_wdata_q <= lat_wdata_d;
            cnt_q       <= cnt_d;
            if (acc_fire) begin
                fifo_q[wptr_q] <= push_data;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_mask[b]) begin
                    mem_q[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_rib_sram_slave.sv
// tb/tb_rib_sram_slave.sv - scoreboard bench for rib_sram_slave (WAIT_CYC=0 and WAIT_CYC=3 instances)
module tb_rib_sram_slave;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2];
    logic        wr [2];
    logic [31:0] addr [2];
    logic [3:0]  mask [2];
    logic [31:0] wdata [2];
    logic        rdy [2];
    logic        gnt [2];
    logic        rsp [2];
    logic [31:0] rdata [2];

    logic        rr_en [2]   = '{1'b0, 1'b0};
    logic        rdy_fix [2] = '{1'b1, 1'b1};
    logic        rnd_rdy [2] = '{1'b1, 1'b1};
    logic        g_s [2]     = '{1'b0, 1'b0};

    assign rdy[0] = rr_en[0] ? rnd_rdy[0] : rdy_fix[0];
    assign rdy[1] = rr_en[1] ? rnd_rdy[1] : rdy_fix[1];

    int checks = 0;
    int failures = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] mdl [int];

    rib_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .WAIT_CYC(0)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_ribs_addr(addr[0]), .i_ribs_wrcs(wr[0]),
        .i_ribs_mask(mask[0]), .i_ribs_wdata(wdata[0]), .o_ribs_rdata(rdata[0]),
        .i_ribs_req(req[0]), .o_ribs_gnt(gnt[0]), .o_ribs_rsp(rsp[0]), .i_ribs_rdy(rdy[0]));

    rib_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .WAIT_CYC(3)) dut3 (
        .i_clk(clk), .i_rst(rst[1]), .i_ribs_addr(addr[1]), .i_ribs_wrcs(wr[1]),
        .i_ribs_mask(mask[1]), .i_ribs_wdata(wdata[1]), .o_ribs_rdata(rdata[1]),
        .i_ribs_req(req[1]), .o_ribs_gnt(gnt[1]), .o_ribs_rsp(rsp[1]), .i_ribs_rdy(rdy[1]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed view of the memory, one flat word map per instance.
    function automatic logic [31:0] model(input int i, input logic w, input logic [31:0] a,
                                          input logic [3:0] m, input logic [31:0] d);
        logic [31:0] off;
        logic [31:0] word;
        int          key;
        logic        inr;
        off = a - BASE;
        key = i * DEPTH + int'(off[13:2]);
`ifdef RIB_SRAM_RANGE_CHK_EN
        inr = (a >= BASE) && (off < 32'(4 * DEPTH));
`else
        inr = 1'b1;
`endif
        word = mdl.exists(key) ? mdl[key] : 32'h0;
        if (w) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) word[8*b +: 8] = d[8*b +: 8];
                mdl[key] = word;
            end
            return 32'h0;
        end
        return inr ? word : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req[i] && g_s[i] && !rst[i]) begin
                if (i == 0) q0.push_back(model(i, wr[i], addr[i], mask[i], wdata[i]));
                else        q1.push_back(model(i, wr[i], addr[i], mask[i], wdata[i]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_rdy[0] = ($urandom_range(0, 3) != 0);
        rnd_rdy[1] = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            g_s[i] = gnt[i];
            if (rsp[i] && rdy[i]) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("unexpected_rsp%0d", i), 32'd1, 32'd0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("rdata%0d", i), rdata[i], e);
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; mask[i] = m; wdata[i] = d;
        while (!done && n < 100) begin
            @(negedge clk);
            done = gnt[i];
            @(posedge clk);
            #1;
            n++;
        end
        req[i] = 1'b0;
        if (!done) check($sformatf("issue_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while ((i == 0 ? q0.size() : q1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check($sformatf("drain_timeout%0d", i), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b1; wr[i] = 1'b0; addr[i] = BASE;
            mask[i] = 4'h0; wdata[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
            check($sformatf("rst_rsp%0d", i), 32'(rsp[i]), 32'd0);
            check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt[0]), 32'd1);
        check("post_rst_gnt1", 32'(gnt[1]), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                issue(i, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom);
        drain(0);
        drain(1);

        // Byte lanes merge across two writes; each response one cycle after accept.
        issue(0, 1'b1, BASE + 32'h10, 4'hF, 32'h1122_3344);
        @(negedge clk); check("lat_wr_full", 32'(rsp[0]), 32'd1);
        @(posedge clk); #1;
        issue(0, 1'b1, BASE + 32'h10, 4'b0101, 32'hAABB_CCDD);
        @(negedge clk); check("lat_wr_mask", 32'(rsp[0]), 32'd1);
        @(posedge clk); #1;
        issue(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        @(negedge clk); check("lat_rd", 32'(rsp[0]), 32'd1);
        @(posedge clk); #1;
        drain(0);

        rdy_fix[0] = 1'b0;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = BASE;
        @(negedge clk); check("bp_gnt1", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1; addr[0] = BASE + 32'h4;
        @(negedge clk); check("bp_gnt2", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1; addr[0] = BASE + 32'h8;
        @(negedge clk); check("bp_gnt3_full", 32'(gnt[0]), 32'd0);
        check("bp_rsp_held", 32'(rsp[0]), 32'd1);
        @(posedge clk); #1; rdy_fix[0] = 1'b1;
        @(negedge clk); check("bp_gnt_pop_cycle", 32'(gnt[0]), 32'd0);
        @(posedge clk); #1; rdy_fix[0] = 1'b0;
        @(negedge clk); check("bp_gnt_reopen", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1; req[0] = 1'b0; rdy_fix[0] = 1'b1;
        drain(0);

        req[0] = 1'b1; wr[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr[0] = BASE + 32'(4 * k);
            @(negedge clk);
            check($sformatf("stream_gnt%0d", k), 32'(gnt[0]), 32'd1);
            if (k > 0) check($sformatf("stream_rsp%0d", k), 32'(rsp[0]), 32'd1);
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
        @(negedge clk); check("stream_rsp_last", 32'(rsp[0]), 32'd1);
        @(negedge clk); check("stream_rsp_done", 32'(rsp[0]), 32'd0);
        @(posedge clk); #1;
        drain(0);

        issue(0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hC0DE_0001);
        issue(0, 1'b0, BASE, 4'h0, 32'h0);
`ifdef RIB_SRAM_RANGE_CHK_EN
        issue(0, 1'b0, BASE - 32'h4, 4'h0, 32'h0);
`endif
        drain(0);

        issue(1, 1'b0, BASE + 32'h14, 4'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("ws_gnt_low%0d", k), 32'(gnt[1]), 32'd0);
            check($sformatf("ws_rsp_low%0d", k), 32'(rsp[1]), 32'd0);
        end
        @(negedge clk);
        check("ws_rsp_n4", 32'(rsp[1]), 32'd1);
        check("ws_gnt_n4", 32'(gnt[1]), 32'd1);
        @(posedge clk); #1;
        drain(1);

        issue(1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        q1.delete();
        @(negedge clk);
        check("wrst_rsp", 32'(rsp[1]), 32'd0);
        check("wrst_gnt", 32'(gnt[1]), 32'd0);
        @(posedge clk); #1; rst[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wrst_idle_rsp%0d", k), 32'(rsp[1]), 32'd0);
            check($sformatf("wrst_idle_gnt%0d", k), 32'(gnt[1]), 32'd1);
        end
        @(posedge clk); #1;
        issue(1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);
        drain(1);

        for (int i = 0; i < 2; i++) begin
            rr_en[i] = 1'b1;
            repeat (60) begin
                issue(i, 1'($urandom), BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
                      4'($urandom), $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
            rr_en[i] = 1'b0;
            drain(i);
        end

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
